pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Next-generation program counter for the pico-MIPS core.
- Supports sequential increment, PC-relative branch, absolute jump, subroutine call and return.
- Call and return use an internal parametrised return-address stack (RAS), with sticky overflow/underflow error flags.
- Drives the instruction-memory address; the decoder supplies the control strobes.

Parameters:
- AddrSz, 6, width of the program address in bits.
- StackDepth, 4, number of RAS entries (≥1).
- ResetAddr, 0, value loaded into addr on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- halt  input  1  freezes all state while high.
- rel_branch  input  1  addr <= addr + offset.
- abs_jump  input  1  addr <= target.
- call  input  1  push addr+1, then addr <= target.
- ret  input  1  pop the top of stack into addr.
- offset  input  AddrSz  two's-complement relative branch offset.
- target  input  AddrSz  absolute jump/call destination.
- addr  output  AddrSz  current program address (registered).
- depth  output  $clog2(StackDepth+1)  number of valid RAS entries.
- stack_full  output  1  depth == StackDepth (combinational from depth).
- stack_empty  output  1  depth == 0 (combinational from depth).
- overflow  output  1  sticky; set by a call when full.
- underflow  output  1  sticky; set by a ret when empty.

Behaviour:
- Reset (n_reset low at the clk edge, highest priority over everything):
  - addr=ResetAddr, depth=0, overflow=0, underflow=0.
  - RAS contents are don't-care.
  - Asserted mid-operation, reset discards any concurrent call/ret/branch.
- Halt: addr, depth, RAS and flags hold; all strobes are ignored.
- Control priority when not halted, one action per cycle: ret > call > abs_jump > rel_branch > increment. Lower-priority strobes asserted at the same time are ignored.
- Increment: addr <= addr + 1.
- rel_branch: addr <= addr + offset.
- Arithmetic is modulo 2^AddrSz; wrap-around is silent, so max+1 -> 0 and 0 + (-1) -> max.
- Offset is the raw AddrSz-bit pattern; adding it modulo 2^AddrSz gives signed behaviour.
- abs_jump: addr <= target; the stack is unchanged.
- call:
  - Return address is addr+1 (mod 2^AddrSz); addr <= target.
  - Not full: push the return address, depth+1.
  - Full: the RAS behaves as a circular buffer. The oldest entry is overwritten, the return address becomes the top, depth stays StackDepth, and overflow <= 1.
- ret:
  - Not empty: addr <= top entry, depth-1.
  - Empty: addr <= addr+1 (treated as a no-op advance), depth stays 0, underflow <= 1.
- Simultaneous call+ret: ret wins; no push occurs.
- Latency: every action takes effect on addr at the next rising edge. There are no bubbles and no multi-cycle operations.
- RAS implementation: circular array indexed by a top pointer mod StackDepth, plus the saturating depth counter.
  - Pushing after an overflow returns the most recent StackDepth addresses in LIFO order.
  - Older addresses are lost.
- overflow and underflow clear only on reset.

Test Plan:
- Reset then 3 free-running cycles (AddrSz=6) -> addr 0,1,2,3; depth 0; stack_empty=1; flags 0.
- Wrap and branch: advance addr to 63, then increment -> 0. Then rel_branch with offset=6'h3E (-2) at addr=1 -> 63.
- Nested calls, StackDepth=4:
  - At addr 5, call target=20 -> addr 20, depth 1.
  - Call target=40 -> addr 40, depth 2.
  - ret -> addr 21.
  - ret -> addr 6; depth 0.
- Overflow: 5 consecutive calls from addr 10 to target 10 -> overflow=1, depth 4, stack_full=1. Then 4 rets -> 11 each time, depth 0, underflow still 0.
- Underflow and priority:
  - ret with an empty stack at addr 8 -> addr 9, underflow=1.
  - Then call+ret+rel_branch together with depth 1, top=30 -> addr 30, depth 0.
- Halt and reset mid-operation:
  - halt high with call asserted -> addr, depth and flags unchanged for 3 cycles.
  - n_reset low concurrent with call -> addr 0, depth 0, flags cleared at the next edge.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: program counter for the pico-MIPS core with a return-address stack.
//
// Each cycle the PC performs exactly one action. The priority is
// reset > halt > ret > call > abs_jump > rel_branch > increment. All address
// arithmetic wraps silently modulo 2^AddrSz.
//
// The return-address stack (RAS) is a circular array. When a call arrives
// with the stack full, the oldest entry is overwritten, so a long call chain
// keeps only the most recent StackDepth return addresses.
//
// Ports:
//   clk          system clock, rising edge
//   n_reset      synchronous active-low reset (highest priority)
//   halt         freezes addr, depth, RAS and flags
//   rel_branch   addr <= addr + offset
//   abs_jump     addr <= target
//   call         push addr+1, addr <= target
//   ret          pop top of stack into addr (empty: addr+1, sets underflow)
//   offset       two's-complement branch offset (AddrSz bits)
//   target       absolute jump/call destination
//   addr         current program address (registered)
//   depth        number of valid RAS entries
//   stack_full   depth == StackDepth
//   stack_empty  depth == 0
//   overflow     sticky: a call happened while full
//   underflow    sticky: a ret happened while empty
module pc_stack #(
  parameter int                AddrSz     = 6,
  parameter int                StackDepth = 4,
  parameter logic [AddrSz-1:0] ResetAddr  = '0
) (
  input  logic                              clk,
  input  logic                              n_reset,
  input  logic                              halt,
  input  logic                              rel_branch,
  input  logic                              abs_jump,
  input  logic                              call,
  input  logic                              ret,
  input  logic [AddrSz-1:0]                 offset,
  input  logic [AddrSz-1:0]                 target,
  output logic [AddrSz-1:0]                 addr,
  output logic [$clog2(StackDepth+1)-1:0]   depth,
  output logic                              stack_full,
  output logic                              stack_empty,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int DepthW = $clog2(StackDepth + 1);
  localparam int PtrW   = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  // Modulo-2^AddrSz add; the delta is signed, so a raw two's-complement
  // offset moves the PC backwards as expected.
  function automatic logic [AddrSz-1:0] add_mod(input logic [AddrSz-1:0]        base,
                                                input logic signed [AddrSz-1:0] delta);
    return base + $unsigned(delta);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(StackDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(StackDepth - 1) : p - PtrW'(1);
  endfunction

  logic [AddrSz-1:0]        ras [StackDepth];
  logic [PtrW-1:0]          wr_ptr;    // next slot to write; when full it is the oldest entry
  logic [PtrW-1:0]          top_ptr;   // most recently pushed entry
  logic signed [AddrSz-1:0] offset_s;
  logic [AddrSz-1:0]        ret_addr;
  logic                     active;
  logic                     push;

  assign offset_s    = $signed(offset);
  assign ret_addr    = add_mod(addr, AddrSz'(1));
  assign top_ptr     = ptr_dec(wr_ptr);
  assign stack_full  = (depth == DepthW'(StackDepth));
  assign stack_empty = (depth == '0);
  assign active      = n_reset && !halt;
  assign push        = active && !ret && call;

  // RAS storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ras[wr_ptr] <= ret_addr;
    end
  end

  // PC, stack pointer, depth and sticky flags.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      addr      <= ResetAddr;
      depth     <= '0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!halt) begin
      if (ret) begin
        if (!stack_empty) begin
          addr   <= ras[top_ptr];
          depth  <= depth - DepthW'(1);
          wr_ptr <= top_ptr;
        end else begin
          addr      <= ret_addr;
          underflow <= 1'b1;
        end
      end else if (call) begin
        addr   <= target;
        wr_ptr <= ptr_inc(wr_ptr);
        if (stack_full) begin
          overflow <= 1'b1;
        end else begin
          depth <= depth + DepthW'(1);
        end
      end else if (abs_jump) begin
        addr <= target;
      end else if (rel_branch) begin
        addr <= add_mod(addr, offset_s);
      end else begin
        addr <= ret_addr;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack (AddrSz=6, StackDepth=4, ResetAddr=0).
// A queue-based reference model holds the return addresses; its back is the
// top of stack and its front is the oldest entry.
module tb_pc_stack;

  localparam int AW = 6;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          n_reset, halt, rel_branch, abs_jump, call, ret;
  logic [AW-1:0] offset, target;
  logic [AW-1:0] addr;
  logic [DW-1:0] depth;
  logic          stack_full, stack_empty, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_addr;
  int m_q[$];
  bit m_ovf, m_unf;

  pc_stack #(.AddrSz(AW), .StackDepth(SD), .ResetAddr('0)) dut (
    .clk(clk), .n_reset(n_reset), .halt(halt), .rel_branch(rel_branch),
    .abs_jump(abs_jump), .call(call), .ret(ret), .offset(offset),
    .target(target), .addr(addr), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit h, input bit rb, input bit aj,
                            input bit c, input bit r, input int off, input int tgt);
    if (!rst_n) begin
      m_addr = 0;
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (!h) begin
      if (r) begin
        if (m_q.size() > 0) m_addr = m_q.pop_back();
        else begin
          m_addr = (m_addr + 1) % 64;
          m_unf  = 1;
        end
      end else if (c) begin
        if (m_q.size() == SD) begin
          m_q   = m_q[1:$];
          m_ovf = 1;
        end
        m_q.push_back((m_addr + 1) % 64);
        m_addr = tgt;
      end else if (aj) begin
        m_addr = tgt;
      end else if (rb) begin
        m_addr = (m_addr + off) % 64;
      end else begin
        m_addr = (m_addr + 1) % 64;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  32'(addr),        32'(m_addr));
    check({tag, ".depth"}, 32'(depth),       32'(m_q.size()));
    check({tag, ".full"},  32'(stack_full),  32'(m_q.size() == SD));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_q.size() == 0));
    check({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    check({tag, ".unf"},   32'(underflow),   32'(m_unf));
  endtask

  // Drive one cycle of stimulus, advance model on the edge, compare 1 time unit later.
  task automatic step(input string tag, input bit rst_n, input bit h, input bit rb,
                      input bit aj, input bit c, input bit r,
                      input logic [AW-1:0] off, input logic [AW-1:0] tgt);
    n_reset = rst_n; halt = h; rel_branch = rb; abs_jump = aj; call = c; ret = r;
    offset = off; target = tgt;
    @(posedge clk);
    model_step(rst_n, h, rb, aj, c, r, int'(off), int'(tgt));
    #1;
    check_all(tag);
  endtask

  task automatic inc(input string tag);      step(tag, 1, 0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic jmp(input logic [AW-1:0] t); step("jmp", 1, 0, 0, 1, 0, 0, 0, t); endtask

  logic [AW-1:0] a0, d0;
  bit            o0, u0;

  initial begin
    m_addr = 0; m_ovf = 0; m_unf = 0;

    // reset and free-running increment
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.addr_const", 32'(addr), 0);
    check("reset.empty_const", 32'(stack_empty), 1);
    for (int i = 1; i <= 3; i++) begin
      inc("run");
      check("run.addr_const", 32'(addr), 32'(i));
    end

    // wrap-around and negative branch
    jmp(6'd63);
    inc("wrap");
    check("wrap.addr_const", 32'(addr), 0);
    inc("wrap1");
    step("relneg", 1, 0, 1, 0, 0, 0, 6'h3E, 0);
    check("relneg.addr_const", 32'(addr), 63);

    // nested calls
    jmp(6'd5);
    step("call20", 1, 0, 0, 0, 1, 0, 0, 6'd20);
    check("call20.addr_const", 32'(addr), 20);
    step("call40", 1, 0, 0, 0, 1, 0, 0, 6'd40);
    check("call40.depth_const", 32'(depth), 2);
    step("ret1", 1, 0, 0, 0, 0, 1, 0, 0);
    check("ret1.addr_const", 32'(addr), 21);
    step("ret2", 1, 0, 0, 0, 0, 1, 0, 0);
    check("ret2.addr_const", 32'(addr), 6);

    // overflow via five calls
    jmp(6'd10);
    for (int i = 0; i < 5; i++) step("ovcall", 1, 0, 0, 0, 1, 0, 0, 6'd10);
    check("ov.flag_const", 32'(overflow), 1);
    check("ov.full_const", 32'(stack_full), 1);
    for (int i = 0; i < 4; i++) begin
      step("ovret", 1, 0, 0, 0, 0, 1, 0, 0);
      check("ovret.addr_const", 32'(addr), 11);
    end
    check("ovret.unf_const", 32'(underflow), 0);

    // underflow, then call+ret+rel_branch priority
    jmp(6'd8);
    step("unf", 1, 0, 0, 0, 0, 1, 0, 0);
    check("unf.addr_const", 32'(addr), 9);
    check("unf.flag_const", 32'(underflow), 1);
    jmp(6'd29);
    step("push30", 1, 0, 0, 0, 1, 0, 0, 6'd50);
    step("prio", 1, 0, 1, 1, 1, 1, 6'd7, 6'd12);
    check("prio.addr_const", 32'(addr), 30);
    check("prio.depth_const", 32'(depth), 0);

    // halt holds everything
    step("push", 1, 0, 0, 0, 1, 0, 0, 6'd17);
    a0 = addr; d0 = depth; o0 = overflow; u0 = underflow;
    for (int i = 0; i < 3; i++) begin
      step("halt", 1, 1, 0, 0, 1, 0, 0, 6'd33);
      check("halt.addr_hold", 32'(addr), 32'(a0));
      check("halt.depth_hold", 32'(depth), 32'(d0));
    end
    check("halt.ovf_hold", 32'(overflow), 32'(o0));
    check("halt.unf_hold", 32'(underflow), 32'(u0));

    // reset concurrent with call
    step("rstcall", 0, 0, 0, 0, 1, 0, 0, 6'd44);
    check("rstcall.addr_const", 32'(addr), 0);
    check("rstcall.unf_const", 32'(underflow), 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit rn, h, rb, aj, c, r;
      rn = ($urandom_range(0, 99) >= 2);
      h  = ($urandom_range(0, 99) < 8);
      r  = ($urandom_range(0, 99) < 25);
      c  = ($urandom_range(0, 99) < 30);
      aj = ($urandom_range(0, 99) < 15);
      rb = ($urandom_range(0, 99) < 25);
      step("rand", rn, h, rb, aj, c, r, AW'($urandom), AW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=%0d", checks, 0);
    $fatal(1, "time limit");
  end

endmodule
